// File: rtl/mult_pkg.sv
// Shared types and widths for the multiplier scheduler.
package mult_pkg;

  localparam int MULT_W = 32;
  localparam int PROD_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } sched_state_t;

  function automatic int cnt_w(input int lat);
    return $clog2(lat) + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr,
// wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_id
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0] idx [NREQ];
  logic           found;

  // idx[k] is the requester examined at priority position k
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_idx
      assign idx[gi] = IDW'((int'(ptr) + gi) % NREQ);
    end
  endgenerate

  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    gnt    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[idx[k]]) begin
        found  = 1'b1;
        gnt_id = idx[k];
      end
    end
    if (found) gnt[gnt_id] = 1'b1;
  end

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one sequential signed multiplier among NREQ clients.
// Optional MULT_SCHED_ZERO_BYPASS_EN: zero operands skip the multiplier and answer next cycle.
module mult_sched
  import mult_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int MULT_LAT = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [MULT_W*NREQ-1:0]   req_a,
  input  logic [MULT_W*NREQ-1:0]   req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [PROD_W-1:0]        rsp_data,
  output logic [MULT_W-1:0]        mult_a,
  output logic [MULT_W-1:0]        mult_b,
  output logic                     mult_start,
  input  logic [MULT_W-1:0]        mult_lo,
  input  logic [MULT_W-1:0]        mult_hi
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = cnt_w(MULT_LAT);

  sched_state_t      state_reg, state_next;
  logic [IDW-1:0]    ptr_reg, ptr_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [MULT_W-1:0] a_reg, a_next, b_reg, b_next;
  logic [IDW-1:0]    id_reg, id_next;
  logic [PROD_W-1:0] data_reg, data_next;
  logic              start_reg, start_next;

  logic [NREQ-1:0]   gnt;
  logic [IDW-1:0]    gnt_id;
  logic [MULT_W-1:0] a_sel, b_sel;
  logic              hs;
  logic              zero_byp;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (req_valid),
    .ptr    (ptr_reg),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // Gate with rst_n so no grant is offered while reset is held
  assign req_ready = (rst_n && state_reg == IDLE) ? gnt : '0;
  assign hs        = |(req_ready & req_valid);
  assign a_sel     = req_a[gnt_id*MULT_W +: MULT_W];
  assign b_sel     = req_b[gnt_id*MULT_W +: MULT_W];

`ifdef MULT_SCHED_ZERO_BYPASS_EN
  assign zero_byp = (a_sel == '0) || (b_sel == '0);
`else
  assign zero_byp = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      id_reg    <= '0;
      data_reg  <= '0;
      start_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      id_reg    <= id_next;
      data_reg  <= data_next;
      start_reg <= start_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    id_next    = id_reg;
    data_next  = data_reg;
    start_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (hs) begin
          id_next = gnt_id;
          if (zero_byp) begin
            data_next  = '0;
            state_next = DONE;
          end else begin
            a_next     = a_sel;
            b_next     = b_sel;
            cnt_next   = CW'(MULT_LAT - 1);
            start_next = 1'b1;
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_reg == '0) begin
          data_next  = {mult_hi, mult_lo};
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_next = IDLE;
          ptr_next   = (id_reg == IDW'(NREQ - 1)) ? '0 : id_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign rsp_valid  = (state_reg == DONE);
  assign rsp_id     = id_reg;
  assign rsp_data   = data_reg;
  assign mult_a     = a_reg;
  assign mult_b     = b_reg;
  assign mult_start = start_reg;

endmodule
